// File: rtl/pfpu_wbtrack_if.sv
// Bus between the PFPU sequencer/ALU result mux and the writeback tracker.
// Issue and result are fire-and-forget pulses with no ready; a dropped issue only shows up on collision.
interface pfpu_wbtrack_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  issue_i;
    logic [3:0]            issue_lat;
    logic [ADDR_WIDTH-1:0] issue_dest;
    logic [31:0]           alu_r;
    logic                  alu_valid;
    logic                  regf_we;
    logic [ADDR_WIDTH-1:0] regf_waddr;
    logic [31:0]           regf_wdata;
    logic                  busy;
    logic                  collision;
    logic                  err_orphan;
    logic                  err_missing;

    modport master (
        output issue_i, issue_lat, issue_dest, alu_r, alu_valid,
        input  regf_we, regf_waddr, regf_wdata, busy, collision, err_orphan, err_missing
    );

    modport slave (
        input  issue_i, issue_lat, issue_dest, alu_r, alu_valid,
        output regf_we, regf_waddr, regf_wdata, busy, collision, err_orphan, err_missing
    );
endinterface

// File: rtl/pfpu_wbtrack.sv
// Delays each issued destination tag by its latency and pairs it with the ALU result at the head slot.
// Define PFPU_WBTRACK_CHECK_EN to build the sticky collision/orphan/missing flags.
module pfpu_wbtrack #(
    parameter int MAXLAT     = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic          sys_clk,
    input  logic          alu_rst,
    pfpu_wbtrack_if.slave bus
);
    logic [MAXLAT-1:0]     slot_v;
    logic [MAXLAT-1:0]     slot_v_nxt;
    logic [ADDR_WIDTH-1:0] slot_d     [MAXLAT];
    logic [ADDR_WIDTH-1:0] slot_d_nxt [MAXLAT];

    logic                  lat_ok;
    logic                  occupied;
    logic                  issue_ok;
    logic                  pair;

    logic                  regf_we_q;
    logic [ADDR_WIDTH-1:0] regf_waddr_q;
    logic [31:0]           regf_wdata_q;

    // Slot s[L] shifts into s[L-1] this cycle, so that is the one that must be free.
    always_comb begin
        lat_ok   = (bus.issue_lat != 4'd0) && (int'(bus.issue_lat) <= MAXLAT);
        occupied = 1'b0;
        for (int k = 1; k < MAXLAT; k++) begin
            if (bus.issue_lat == 4'(k) && slot_v[k]) occupied = 1'b1;
        end
        issue_ok = bus.issue_i && lat_ok && !occupied;

        slot_v_nxt = slot_v >> 1;
        for (int k = 0; k < MAXLAT - 1; k++) begin
            slot_d_nxt[k] = slot_d[k+1];
        end
        slot_d_nxt[MAXLAT-1] = '0;
        for (int k = 0; k < MAXLAT; k++) begin
            if (issue_ok && bus.issue_lat == 4'(k + 1)) begin
                slot_v_nxt[k] = 1'b1;
                slot_d_nxt[k] = bus.issue_dest;
            end
        end
    end

    assign pair = slot_v[0] && bus.alu_valid;

    always_ff @(posedge sys_clk) begin
        if (alu_rst) begin
            slot_v       <= '0;
            regf_we_q    <= 1'b0;
            regf_waddr_q <= '0;
            regf_wdata_q <= '0;
            for (int k = 0; k < MAXLAT; k++) slot_d[k] <= '0;
        end else begin
            slot_v    <= slot_v_nxt;
            regf_we_q <= pair;
            for (int k = 0; k < MAXLAT; k++) slot_d[k] <= slot_d_nxt[k];
            if (pair) begin
                regf_waddr_q <= slot_d[0];
                regf_wdata_q <= bus.alu_r;
            end
        end
    end

    assign bus.regf_we    = regf_we_q;
    assign bus.regf_waddr = regf_waddr_q;
    assign bus.regf_wdata = regf_wdata_q;
    assign bus.busy       = (|slot_v) || regf_we_q;

`ifdef PFPU_WBTRACK_CHECK_EN
    logic orphan;
    logic missing;
    logic collision_q;
    logic orphan_q;
    logic missing_q;

    assign orphan  = bus.alu_valid && !slot_v[0];
    assign missing = slot_v[0] && !bus.alu_valid;

    always_ff @(posedge sys_clk) begin
        if (alu_rst) begin
            collision_q <= 1'b0;
            orphan_q    <= 1'b0;
            missing_q   <= 1'b0;
        end else begin
            if (bus.issue_i && !issue_ok) collision_q <= 1'b1;
            if (orphan)                   orphan_q    <= 1'b1;
            if (missing)                  missing_q   <= 1'b1;
        end
    end

    assign bus.collision   = collision_q;
    assign bus.err_orphan  = orphan_q;
    assign bus.err_missing = missing_q;
`else
    assign bus.collision   = 1'b0;
    assign bus.err_orphan  = 1'b0;
    assign bus.err_missing = 1'b0;
`endif
endmodule

// File: tb/tb_pfpu_wbtrack.sv
// Directed bench for pfpu_wbtrack; flag expectations follow PFPU_WBTRACK_CHECK_EN.
module tb_pfpu_wbtrack;
    localparam int AW = 7;
`ifdef PFPU_WBTRACK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk;
    logic alu_rst;
    int   n_checks;
    int   n_pass;
    logic [AW+31:0] exp_q[$];

    pfpu_wbtrack_if #(.ADDR_WIDTH(AW)) bus ();

    pfpu_wbtrack #(.MAXLAT(8), .ADDR_WIDTH(AW)) dut (
        .sys_clk (clk),
        .alu_rst (alu_rst),
        .bus     (bus.slave)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scoreboard: every observed write must match the oldest expected write
    task automatic tick();
        logic [AW+31:0] e;
        @(posedge clk);
        #1;
        if (bus.regf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_we", 64'(bus.regf_we), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_waddr", 64'(bus.regf_waddr), 64'(e[AW+31:32]));
                check("sb_wdata", 64'(bus.regf_wdata), 64'(e[31:0]));
            end
        end
    endtask

    // driver tasks
    task automatic idle();
        bus.issue_i    = 1'b0;
        bus.issue_lat  = 4'd0;
        bus.issue_dest = '0;
        bus.alu_valid  = 1'b0;
        bus.alu_r      = 32'd0;
    endtask

    task automatic issue(input logic [3:0] lat, input logic [AW-1:0] dest);
        bus.issue_i    = 1'b1;
        bus.issue_lat  = lat;
        bus.issue_dest = dest;
    endtask

    task automatic result(input logic [31:0] r);
        bus.alu_valid = 1'b1;
        bus.alu_r     = r;
    endtask

    task automatic reset_dut();
        idle();
        alu_rst = 1'b1;
        tick();
        alu_rst = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic we, input logic busy,
                              input logic col, input logic orph, input logic miss);
        check({tag, "_we"},      64'(bus.regf_we),     64'(we));
        check({tag, "_busy"},    64'(bus.busy),        64'(busy));
        check({tag, "_col"},     64'(bus.collision),   64'(col & CHK));
        check({tag, "_orphan"},  64'(bus.err_orphan),  64'(orph & CHK));
        check({tag, "_missing"}, 64'(bus.err_missing), 64'(miss & CHK));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();
        alu_rst = 1'b1;
        tick();
        tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_waddr", 64'(bus.regf_waddr), 64'd0);
        check("reset_wdata", 64'(bus.regf_wdata), 64'd0);
        alu_rst = 1'b0;

        // latency-1 pairing
        issue(4'd1, 7'd5);
        tick();
        expect_out("s1_c1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        result(32'h3F80_0000);
        exp_q.push_back({7'd5, 32'h3F80_0000});
        tick();
        expect_out("s1_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s1_waddr", 64'(bus.regf_waddr), 64'd5);
        check("s1_wdata", 64'(bus.regf_wdata), 64'h3F80_0000);
        idle();
        tick();
        expect_out("s1_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s1_hold_waddr", 64'(bus.regf_waddr), 64'd5);
        check("s1_hold_wdata", 64'(bus.regf_wdata), 64'h3F80_0000);

        // back-to-back L=4 issues, results at cycles 4..7
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 4) issue(4'd4, 7'(c + 1));
            if (c >= 4 && c <= 7) begin
                result(32'(10 + c - 4));
                exp_q.push_back({7'(c - 3), 32'(10 + c - 4)});
            end
            tick();
            check("s2_we", 64'(bus.regf_we), 64'(c >= 4 && c <= 7));
        end
        expect_out("s2_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s2_last_waddr", 64'(bus.regf_waddr), 64'd4);
        check("s2_last_wdata", 64'(bus.regf_wdata), 64'hD);

        // slot collision: L=3 then L=2 target the same slot
        reset_dut();
        issue(4'd3, 7'd9);
        tick();
        issue(4'd2, 7'd7);
        tick();
        idle();
        expect_out("s3_c2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        result(32'h0000_1234);
        exp_q.push_back({7'd9, 32'h0000_1234});
        tick();
        idle();
        expect_out("s3_c4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("s3_waddr", 64'(bus.regf_waddr), 64'd9);
        tick();
        expect_out("s3_c5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // orphan result, sticky until reset
        reset_dut();
        result(32'hDEAD_BEEF);
        tick();
        idle();
        expect_out("s4_c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("s4_c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_dut();
        expect_out("s4_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // missing result, then latency 0 and latency 9 issues
        issue(4'd2, 7'd3);
        tick();
        idle();
        tick();
        expect_out("s5_c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("s5_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 7'd1);
        tick();
        idle();
        expect_out("s5_c4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        reset_dut();
        issue(4'd9, 7'd2);
        tick();
        idle();
        expect_out("s5_lat9", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset mid-flight discards the pending tag
        reset_dut();
        issue(4'd8, 7'h55);
        tick();
        idle();
        tick();
        tick();
        tick();
        alu_rst = 1'b1;
        tick();
        expect_out("s6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_rst = 1'b0;
        tick();
        tick();
        tick();
        result(32'h4000_0000);
        tick();
        idle();
        expect_out("s6_c9", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("s6_waddr", 64'(bus.regf_waddr), 64'd0);
        tick();

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
